// File: rtl/fpu_pkg.sv
// Shared binary32 types, constants and operand classification for the FPU blocks.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,  // zero or denormal (denormals are flushed)
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int          FP_BIAS = 127;

  // Bit positions inside the {overflow, underflow, invalid} flag vector.
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INV = 0;

  function automatic fp_class_t fp_classify(input fp32_t f);
    fp_class_t c;
    if (f.exp == 8'h00) begin
      c = FP_ZERO;
    end else if (f.exp == 8'hFF) begin
      c = (f.man == 23'd0) ? FP_INF : FP_NAN;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalise, round and special-case a raw 48-bit significand product into a
// binary32 result plus {overflow, underflow, invalid}. Purely combinational so
// it can be dropped into any pipeline stage (also used by the fma datapath).
module fmul_round
  import fpu_pkg::*;
#(
  parameter int RNE = 1
) (
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_sum,   // e1 + e2 - bias, before normalisation
  input  fp_class_t         cls_a,
  input  fp_class_t         cls_b,
  input  logic              sign,
  output logic [31:0]       y,
  output logic [2:0]        flags
);

  logic              norm;
  logic [22:0]       man_t;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       man_r;
  logic signed [9:0] exp_r;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero;

  // Normalise on bit 47, round the kept mantissa, then apply special cases in priority order.
  always_comb begin
    norm = prod[47];
    if (norm) begin
      man_t  = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      man_t  = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    // Round half to even; truncation mode simply never rounds up.
    round_up = (RNE != 0) && guard && (sticky || man_t[0]);
    man_r    = {1'b0, man_t} + {23'd0, round_up};
    // A mantissa carry-out leaves man_r[22:0] at zero, i.e. 1.0 at the next exponent.
    exp_r    = exp_sum + $signed({9'd0, norm}) + $signed({9'd0, man_r[23]});

    is_nan  = (cls_a == FP_NAN) || (cls_b == FP_NAN) ||
              ((cls_a == FP_INF) && (cls_b == FP_ZERO)) ||
              ((cls_a == FP_ZERO) && (cls_b == FP_INF));
    is_inf  = (cls_a == FP_INF) || (cls_b == FP_INF);
    is_zero = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);

    y     = {sign, exp_r[7:0], man_r[22:0]};
    flags = 3'b000;
    if (is_nan) begin
      y               = FP_QNAN;
      flags[FLAG_INV] = 1'b1;
    end else if (is_inf) begin
      y = {sign, 8'hFF, 23'd0};
    end else if (is_zero) begin
      y = {sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      y               = {sign, 8'hFF, 23'd0};
      flags[FLAG_OVF] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      y               = {sign, 31'd0};
      flags[FLAG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Fully pipelined binary32 multiplier with valid/ready handshake and a sideband tag.
// Stage 1 classifies operands and forms two significand partial products, stage 2
// sums/rounds/special-cases, stages 3..STAGES only retime the result. A single
// global enable (no stall) moves every stage together.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TAG_W  = 5,
  parameter int RNE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("fmul_pipe: STAGES must be within 2..4");
  end

  logic  stall;
  logic  adv;
  fp32_t op_a;
  fp32_t op_b;
  logic [23:0] sig_a;
  logic [23:0] sig_b;
  logic [36:0] p_hi_next;
  logic [34:0] p_lo_next;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  assign op_a  = x1;
  assign op_b  = x2;
  assign sig_a = {1'b1, op_a.man};
  assign sig_b = {1'b1, op_b.man};
  // 24x13 and 24x11 partials; stage 2 recombines them with an 11-bit shift.
  assign p_hi_next = {13'd0, sig_a} * {24'd0, sig_b[23:11]};
  assign p_lo_next = {11'd0, sig_a} * {24'd0, sig_b[10:0]};

  logic             s1_valid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s1_sign_reg;
  logic [7:0]       s1_exp_a_reg;
  logic [7:0]       s1_exp_b_reg;
  fp_class_t        s1_cls_a_reg;
  fp_class_t        s1_cls_b_reg;
  logic [36:0]      s1_p_hi_reg;
  logic [34:0]      s1_p_lo_reg;

  // Stage 1: capture operand fields, classes and partial products; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s1_tag_reg   <= in_tag;
      s1_sign_reg  <= op_a.sign ^ op_b.sign;
      s1_exp_a_reg <= op_a.exp;
      s1_exp_b_reg <= op_b.exp;
      s1_cls_a_reg <= fp_classify(op_a);
      s1_cls_b_reg <= fp_classify(op_b);
      s1_p_hi_reg  <= p_hi_next;
      s1_p_lo_reg  <= p_lo_next;
    end
  end

  logic [47:0]       prod;
  logic signed [9:0] exp_sum;
  logic [31:0]       rnd_y;
  logic [2:0]        rnd_flags;

  assign prod    = {s1_p_hi_reg, 11'd0} + {13'd0, s1_p_lo_reg};
  assign exp_sum = $signed({2'b00, s1_exp_a_reg}) + $signed({2'b00, s1_exp_b_reg}) - 10'(FP_BIAS);

  fmul_round #(.RNE(RNE)) u_round (
    .prod    (prod),
    .exp_sum (exp_sum),
    .cls_a   (s1_cls_a_reg),
    .cls_b   (s1_cls_b_reg),
    .sign    (s1_sign_reg),
    .y       (rnd_y),
    .flags   (rnd_flags)
  );

  logic             stg_valid_reg [2:STAGES];
  logic [31:0]      stg_y_reg     [2:STAGES];
  logic [TAG_W-1:0] stg_tag_reg   [2:STAGES];
  logic [2:0]       stg_flags_reg [2:STAGES];

  // Stage 2 captures the rounded result; later stages are plain retiming of the same fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 2; i <= STAGES; i++) begin
        stg_valid_reg[i] <= 1'b0;
        stg_y_reg[i]     <= 32'd0;
        stg_tag_reg[i]   <= '0;
        stg_flags_reg[i] <= 3'b000;
      end
    end else if (adv) begin
      stg_valid_reg[2] <= s1_valid_reg;
      stg_y_reg[2]     <= rnd_y;
      stg_tag_reg[2]   <= s1_tag_reg;
      stg_flags_reg[2] <= rnd_flags;
      for (int i = 3; i <= STAGES; i++) begin
        stg_valid_reg[i] <= stg_valid_reg[i-1];
        stg_y_reg[i]     <= stg_y_reg[i-1];
        stg_tag_reg[i]   <= stg_tag_reg[i-1];
        stg_flags_reg[i] <= stg_flags_reg[i-1];
      end
    end
  end

  assign out_valid = stg_valid_reg[STAGES];
  assign y         = stg_y_reg[STAGES];
  assign out_tag   = stg_tag_reg[STAGES];
  assign flags     = stg_flags_reg[STAGES];

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: three instances (STAGES=3/RNE, STAGES=2/truncate,
// STAGES=4/RNE) share one stimulus stream; each has its own expected-result queue
// that an independent monitor drains whenever that instance hands over a result.
module tb_fmul_pipe;

  localparam int TAG_W = 5;
  localparam int ST_A  = 3;
  localparam int ST_B  = 2;
  localparam int ST_C  = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;   // expected with round-to-nearest-even
    logic [31:0] et;   // expected with truncation
    logic [2:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0]      y;
    logic [2:0]       fl;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               lat;
  } sb_t;

  localparam vec_t DIR_V [9] = '{
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F800002, 3'b000},
    '{32'h3F800800, 32'h3F800800, 32'h3F801000, 32'h3F801000, 3'b000},
    '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 32'h407FFFFE, 3'b000},
    '{32'h3F800A00, 32'h3F800A00, 32'h3F801401, 32'h3F801400, 3'b000},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b100},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 3'b010},
    '{32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 3'b001},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 3'b000},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 3'b000}
  };

  localparam vec_t STR_V [16] = '{
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000},
    '{32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 3'b000},
    '{32'h40400000, 32'h40400000, 32'h41100000, 32'h41100000, 3'b000},
    '{32'h40A00000, 32'h40E00000, 32'h420C0000, 32'h420C0000, 3'b000},
    '{32'hBF800000, 32'h40000000, 32'hC0000000, 32'hC0000000, 3'b000},
    '{32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 3'b000},
    '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3E000000, 3'b000},
    '{32'h7F800000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b000},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b001},
    '{32'h00000001, 32'h40000000, 32'h00000000, 32'h00000000, 3'b000},
    '{32'h41200000, 32'h41200000, 32'h42C80000, 32'h42C80000, 3'b000},
    '{32'hC0400000, 32'h40800000, 32'hC1400000, 32'hC1400000, 3'b000},
    '{32'h3F800A00, 32'h3F800A00, 32'h3F801401, 32'h3F801400, 3'b000},
    '{32'h3F800800, 32'h3F800800, 32'h3F801000, 32'h3F801000, 3'b000},
    '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 32'h407FFFFE, 3'b000},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b100}
  };

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [31:0]      x1 = 32'd0;
  logic [31:0]      x2 = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;

  logic [2:0]       ov;
  logic [2:0]       rdy;
  logic [31:0]      yv [3];
  logic [TAG_W-1:0] tg [3];
  logic [2:0]       fv [3];

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];

  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;
  logic [TAG_W-1:0] tag_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmul_pipe #(.STAGES(ST_A), .TAG_W(TAG_W), .RNE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .x1(x1), .x2(x2),
    .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .y(yv[0]),
    .out_tag(tg[0]), .flags(fv[0]));

  fmul_pipe #(.STAGES(ST_B), .TAG_W(TAG_W), .RNE(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .x1(x1), .x2(x2),
    .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .y(yv[1]),
    .out_tag(tg[1]), .flags(fv[1]));

  fmul_pipe #(.STAGES(ST_C), .TAG_W(TAG_W), .RNE(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .x1(x1), .x2(x2),
    .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .y(yv[2]),
    .out_tag(tg[2]), .flags(fv[2]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  // One clock of stimulus: set out_ready, then optionally present an operand pair
  // once every instance can take it, queueing the expected result for each.
  task automatic step(input bit v, input vec_t vec, input bit lat, input bit ordy);
    int  waited;
    sb_t e;
    @(posedge clk);
    #1;
    out_ready = ordy;
    in_valid  = 1'b0;
    #1;
    if (v) begin
      waited = 0;
      while (rdy != 3'b111 && waited < 50) begin
        @(posedge clk);
        #2;
        waited++;
      end
      if (waited >= 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue_timeout: in_ready=%b, expected 111 within 50 cycles", rdy);
      end else begin
        x1       = vec.a;
        x2       = vec.b;
        in_tag   = tag_cnt;
        in_valid = 1'b1;
        e.y   = vec.er;
        e.fl  = vec.fl;
        e.tag = tag_cnt;
        e.cyc = cyc;
        e.lat = lat;
        q0.push_back(e);
        q2.push_back(e);
        e.y = vec.et;
        q1.push_back(e);
        tag_cnt = tag_cnt + 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    vec_t z;
    z = '0;
    repeat (n) step(1'b0, z, 1'b0, 1'b1);
  endtask

  // Monitor: pops and compares on every handshake, and checks outputs hold while stalled.
  initial begin
    sb_t              e;
    bit               have;
    logic             hv [3];
    logic [31:0]      hy [3];
    logic [TAG_W-1:0] ht [3];
    logic [2:0]       hf [3];
    int               lat_exp;
    for (int k = 0; k < 3; k++) hv[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          hv[k] = 1'b0;
        end else begin
          if (hv[k]) begin
            chk("hold_valid", k, {31'd0, ov[k]}, 32'd1);
            chk("hold_y", k, yv[k], hy[k]);
            chk("hold_tag", k, {27'd0, tg[k]}, {27'd0, ht[k]});
            chk("hold_flags", k, {29'd0, fv[k]}, {29'd0, hf[k]});
          end
          hv[k] = ov[k] && !out_ready;
          hy[k] = yv[k];
          ht[k] = tg[k];
          hf[k] = fv[k];
          if (ov[k] && out_ready) begin
            have = 1'b0;
            case (k)
              0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
              1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
              default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_out dut%0d: got y=%h tag=%0d, expected no output", k, yv[k], tg[k]);
            end else begin
              $display("dut%0d tag=%0d y=%h flags=%b (expected y=%h flags=%b)", k, tg[k], yv[k], fv[k], e.y, e.fl);
              chk("y", k, yv[k], e.y);
              chk("flags", k, {29'd0, fv[k]}, {29'd0, e.fl});
              chk("tag", k, {27'd0, tg[k]}, {27'd0, e.tag});
              if (e.lat) begin
                lat_exp = (k == 0) ? ST_A : ((k == 1) ? ST_B : ST_C);
                chk("latency", k, cyc - e.cyc, lat_exp);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t basic;
    vec_t pr;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", k, {31'd0, ov[k]}, 32'd0);
      chk("reset_y", k, yv[k], 32'd0);
      chk("reset_tag", k, {27'd0, tg[k]}, 32'd0);
      chk("reset_flags", k, {29'd0, fv[k]}, 32'd0);
      chk("reset_in_ready", k, {31'd0, rdy[k]}, 32'd1);
    end

    // Isolated op with latency check.
    tag_cnt = 5'd7;
    basic = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40400000, 3'b000};
    step(1'b1, basic, 1'b1, 1'b1);
    idle(8);

    // Rounding and special cases.
    for (int i = 0; i < 9; i++) step(1'b1, DIR_V[i], 1'b0, 1'b1);
    idle(8);

    // Back-to-back stream with a 5-cycle backpressure window in the middle.
    tag_cnt = '0;
    for (int i = 0; i < 8; i++) step(1'b1, STR_V[i], 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) begin
      step(1'b0, STR_V[0], 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) chk("stall_in_ready", k, {31'd0, rdy[k]}, 32'd0);
    end
    for (int i = 8; i < 16; i++) step(1'b1, STR_V[i], 1'b0, 1'b1);
    idle(10);

    // Reset with two operations in flight: nothing from before the reset may appear.
    tag_cnt = 5'd20;
    step(1'b1, STR_V[1], 1'b0, 1'b1);
    step(1'b1, STR_V[2], 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_out_valid", k, {31'd0, ov[k]}, 32'd0);
      chk("post_rst_in_ready", k, {31'd0, rdy[k]}, 32'd1);
    end
    for (int s = 0; s < 8; s++) begin
      step(1'b0, STR_V[0], 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) chk("post_rst_idle", k, {31'd0, ov[k]}, 32'd0);
    end

    // Pipeline still works after the mid-flight reset.
    pr = '{32'h40400000, 32'h40400000, 32'h41100000, 32'h41100000, 3'b000};
    step(1'b1, pr, 1'b1, 1'b1);
    idle(8);

    chk("drain_queue", 0, q0.size(), 32'd0);
    chk("drain_queue", 1, q1.size(), 32'd0);
    chk("drain_queue", 2, q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
